// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the scanning display multiplexer and its helpers.
//   - MODE_AUTO / MODE_MANUAL : encoding of the Mode input.
//   - clog2()                 : ceiling log2 for flows lacking $clog2 in
//                               parameter expressions (clog2(1) = 0).
// ---------------------------------------------------------------------------
package mux_pkg;

   localparam logic MODE_AUTO   = 1'b0;
   localparam logic MODE_MANUAL = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage : mux_pkg

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Prescaler producing a one-cycle tick on the last count of each period
//   (count PRESCALE-1). The counter runs 0..PRESCALE-1 while en=1 and holds
//   while en=0. clr (qualified by en) forces the count back to 0 and masks
//   the tick, so a period restarted by clr is always a full PRESCALE cycles.
//
//   Ports:
//     clk   in  1  rising-edge clock
//     rst_n in  1  asynchronous active-low reset (count -> 0)
//     en    in  1  count enable; 0 freezes the counter and masks the tick
//     clr   in  1  hold counter at 0 (while enabled)
//     tick  out 1  high in the cycle the counter sits at PRESCALE-1
// ---------------------------------------------------------------------------
module tick_gen
   import mux_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   // At least one counter bit so PRESCALE=1 still elaborates; the counter
   // then sits at 0 and the tick fires every enabled cycle.
   localparam int unsigned CNT_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         if (clr || at_last) cnt_d = '0;
         else                cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick = en & ~clr & at_last;

endmodule : tick_gen

// File: rtl/mux_scan_nto1.sv
// ---------------------------------------------------------------------------
// mux_scan_nto1
//   Registered N-to-1 word multiplexer feeding the display drivers. The
//   channel either auto-scans (one channel per PRESCALE cycles) or follows
//   Sel. Per-channel blanking suppresses both the word and the one-hot
//   enable of the current channel.
//
//   Ports:
//     Clk    in   1              rising-edge clock
//     Rst_n  in   1              asynchronous active-low reset
//     En     in   1              global enable; 0 freezes all state
//     Mode   in   1              0 = auto-scan, 1 = manual select
//     Sel    in   SEL_W          manual channel index (>= NUM_CH ignored)
//     W      in   NUM_CH*DATA_W  channel words, channel k at W[k*DATA_W +: DATA_W]
//     Blank  in   NUM_CH         per-channel blank mask, 1 = suppressed
//     F      out  DATA_W         registered selected word
//     Ch     out  SEL_W          registered current channel index
//     Ch_en  out  NUM_CH         registered one-hot enable of current channel
//     Wrap   out  1              one-cycle pulse on auto step NUM_CH-1 -> 0
// ---------------------------------------------------------------------------
module mux_scan_nto1
   import mux_pkg::*;
#(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned NUM_CH   = 16,
   parameter int unsigned SEL_W    = clog2(NUM_CH),
   parameter int unsigned PRESCALE = 50000
)(
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     En,
   input  logic                     Mode,
   input  logic [SEL_W-1:0]         Sel,
   input  logic [NUM_CH*DATA_W-1:0] W,
   input  logic [NUM_CH-1:0]        Blank,
   output logic [DATA_W-1:0]        F,
   output logic [SEL_W-1:0]         Ch,
   output logic [NUM_CH-1:0]        Ch_en,
   output logic                     Wrap
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   logic              tick;
   logic              manual;
   logic              sel_ok;
   logic [SEL_W-1:0]  ch_next;

   logic [SEL_W-1:0]  ch_q,   ch_d;
   logic [NUM_CH-1:0] chen_q, chen_d;
   logic [DATA_W-1:0] f_q,    f_d;
   logic              wrap_q, wrap_d;

   assign manual = (Mode == MODE_MANUAL);
   assign sel_ok = (32'(Sel) < NUM_CH);

   // Prescaler is cleared in manual mode so that a return to auto mode
   // starts with a full slot on the current channel.
   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk   (Clk),
      .rst_n (Rst_n),
      .en    (En),
      .clr   (manual),
      .tick  (tick)
   );

   // Next channel: auto steps on the prescaler tick, manual follows an
   // in-range Sel and otherwise keeps the current channel.
   always_comb begin
      ch_next = ch_q;
      if (!manual) begin
         if (tick) ch_next = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
      end else if (sel_ok) begin
         ch_next = Sel;
      end
   end

   // Decode and word select are both driven from ch_next so Ch, Ch_en and F
   // always describe the same channel in the same cycle.
   always_comb begin
      ch_d   = ch_q;
      chen_d = chen_q;
      f_d    = f_q;
      if (En) begin
         ch_d   = ch_next;
         chen_d = '0;
         f_d    = '0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_next == SEL_W'(k) && !Blank[k]) begin
               chen_d[k] = 1'b1;
               f_d       = W[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // tick is already qualified by En and by auto mode, so Wrap drops to 0
   // on any disabled or manual cycle.
   always_comb begin
      wrap_d = tick & (ch_q == LAST_CH);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ch_q   <= '0;
         chen_q <= '0;
         f_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         ch_q   <= ch_d;
         chen_q <= chen_d;
         f_q    <= f_d;
         wrap_q <= wrap_d;
      end
   end

   assign F     = f_q;
   assign Ch    = ch_q;
   assign Ch_en = chen_q;
   assign Wrap  = wrap_q;

endmodule : mux_scan_nto1

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised, registered N-to-1 multiplexer. Successor to the fixed 16:1 4-bit combinational mux.
- Adds two select modes:
  - auto-scan: a prescaled counter steps through all channels, e.g. for time-multiplexed display digits.
  - manual: channel taken from the Sel input.
- Also adds per-channel blanking, a one-hot channel-enable output and a wrap pulse.
- Sits between the ATM datapath (balance/PIN digits) and the display drivers.

Parameters:
- DATA_W, 4, width of each channel word.
- NUM_CH, 16, number of input channels (2..256).
- SEL_W, $clog2(NUM_CH), width of channel index.
- PRESCALE, 50000, clock cycles per auto-scan slot (>=1).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- En  input  1  global enable; 0 freezes all state.
- Mode  input  1  0 = auto-scan, 1 = manual select.
- Sel  input  SEL_W  manual channel index.
- W  input  NUM_CH*DATA_W  flattened channel words; channel k at W[k*DATA_W +: DATA_W].
- Blank  input  NUM_CH  per-channel blank mask; 1 = channel suppressed.
- F  output  DATA_W  registered selected word.
- Ch  output  SEL_W  registered current channel index.
- Ch_en  output  NUM_CH  registered one-hot enable of current channel.
- Wrap  output  1  one-cycle pulse when auto-scan steps from NUM_CH-1 to 0.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - F=0, Ch=0, Ch_en=0, Wrap=0, prescaler=0.
  - Reset mid-scan abandons the current slot immediately.
- Next-channel value ch_next is computed combinationally each cycle.
  - Auto mode (Mode=0):
    - prescaler counts 0..PRESCALE-1.
    - At PRESCALE-1: ch_next = Ch+1, wrapping NUM_CH-1 -> 0, and prescaler -> 0.
    - Otherwise ch_next = Ch.
  - Manual mode (Mode=1):
    - If Sel < NUM_CH, ch_next = Sel; otherwise ch_next = Ch (out-of-range select ignored).
    - prescaler held at 0.
- Register update, every cycle with En=1:
  - Ch <= ch_next.
  - Ch_en <= onehot(ch_next) & ~Blank.
  - F <= Blank[ch_next] ? 0 : W[ch_next].
  - Ch, Ch_en and F are therefore always mutually aligned.
- Latency:
  - A change on W or Blank appears on F/Ch_en one cycle later.
  - In manual mode, a Sel change appears one cycle later.
- Wrap:
  - Wrap <= 1 for exactly one cycle when the auto step goes from NUM_CH-1 to 0; otherwise 0.
  - Never asserted in manual mode.
- En=0: all registers hold, including prescaler. Wrap is forced to 0 on the next edge.
- Mode switch:
  - Auto->manual takes effect next cycle.
  - Manual->auto resumes from current Ch with prescaler=0, so the first slot is a full PRESCALE cycles.
- PRESCALE=1: channel advances every enabled cycle.
- All channels blanked: Ch keeps scanning, Ch_en=0, F=0.
- Mode and Sel are synchronous inputs, sampled on Clk; no internal synchronisers.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_AUTO=1'b0 and MODE_MANUAL=1'b1.
  - A clog2 helper function for older tool flows.
- One natural sub-module, tick_gen:
  - Parametrised prescaler producing a one-cycle tick at PRESCALE-1.
  - Has En and clear inputs.
  - Reused by other display and timeout blocks.
- One-hot decode and word select stay inline.

Test Plan:
- Reset release, NUM_CH=4, PRESCALE=3, W=ch0..3={1,2,3,4}, Mode=0:
  - F/Ch go 1/0 for 3 cycles, then 2/1, 3/2, 4/3, 1/0.
  - Ch_en shows 0001, 0010, 0100, 1000.
  - Wrap pulses once on the 3->0 step.
- Manual mode with Sel=2 then Sel=7 (out of range, NUM_CH=4):
  - F=3 and Ch=2 one cycle after Sel=2.
  - Sel=7 leaves Ch=2 and F=3 unchanged; Wrap stays 0 throughout.
- Blank=4'b0100 during auto scan:
  - When Ch=2: F=0, Ch_en=0000.
  - Other slots unaffected.
  - Blank=4'b1111 gives Ch_en=0 and F=0 for all slots while Ch still counts.
- En deasserted mid-slot (prescaler=1, Ch=1) for 5 cycles, then reasserted:
  - Outputs frozen during the 5 cycles.
  - After En returns, 2 more cycles pass before Ch=2.
- Rst_n pulled low asynchronously mid-slot with Ch=3:
  - F, Ch, Ch_en and Wrap go to 0 without waiting for a clock edge.
  - Scan restarts at ch0 with a full slot.
- Default parameters (16 channels, 4 bits), manual mode, Sel swept 0..15:
  - F equals W[Sel] one cycle after each Sel change, matching the legacy 16:1 mux truth table.
